// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the write-side and read-side controllers of the
// dual-clock FIFO.
//   depth_of  : number of memory slots for a given address width
//   bin2gray  : binary to reflected Gray code
//   gray2bin  : Gray to binary, XOR prefix running down from the MSB
// The converters work on a 32-bit container. Callers zero-extend narrower
// pointers; zero upper bits leave both conversions exact for the low bits.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int PTR_MAX_W = 32;

   function automatic int depth_of(input int asize);
      return 1 << asize;
   endfunction

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wptr_full_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a multi-bit Gray-coded bus. Only one bit of the
// bus changes per source update, so each bit can be synchronised on its own.
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, both stages clear to 0
//   i_d      bus from the foreign clock domain
//   o_q      bus after two destination-clock flops
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q1;
   logic [WIDTH-1:0] r_q2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q1 <= '0;
         r_q2 <= '0;
      end else begin
         r_q1 <= i_d;
         r_q2 <= r_q1;
      end
   end

   assign o_q = r_q2;

endmodule

// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
// Write-side controller of the dual-clock FIFO. Owns the binary/Gray write
// pointer, synchronises the read-side Gray pointer into wclk and produces the
// registered full, almost-full and free-slot outputs.
// Ports:
//   wclk          write clock
//   wrst_n        asynchronous active-low reset (deassert synchronously)
//   winc          write request from the producer
//   rptr_gray     Gray read pointer from the read domain (asynchronous)
//   waddr         memory write address (low ASIZE bits of the binary pointer)
//   wclk_en       memory write enable, winc & ~wfull
//   wptr_gray     registered Gray write pointer, to the read domain
//   wfull         registered full flag
//   walmost_full  registered, set when free slots <= AF_LEVEL
//   wfree_cnt     registered free slot count, 0..DEPTH
//   woverflow     sticky write-while-full flag, present only when the
//                 macro WPTR_OVERFLOW_FLAG_EN is defined
// -----------------------------------------------------------------------------
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int DSIZE    = 6,
   parameter int ASIZE    = 4,
   parameter int AF_LEVEL = 2
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             winc,
   input  logic [ASIZE:0]   rptr_gray,
   output logic [ASIZE-1:0] waddr,
   output logic             wclk_en,
   output logic [ASIZE:0]   wptr_gray,
   output logic             wfull,
   output logic             walmost_full,
   output logic [ASIZE:0]   wfree_cnt
`ifdef WPTR_OVERFLOW_FLAG_EN
   ,
   output logic             woverflow
`endif
);

   localparam int             DEPTH   = depth_of(ASIZE);
   localparam logic [ASIZE:0] DEPTH_W = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AF_W    = (ASIZE+1)'(AF_LEVEL);

   // DSIZE only documents the width of the memory this block addresses.
   if (ASIZE < 2 || AF_LEVEL <= 0 || AF_LEVEL >= DEPTH || DSIZE < 1) begin : g_bad_param
      $error("fifo_wptr_full: illegal parameter set");
   end

   logic [ASIZE:0] r_wbin;
   logic [ASIZE:0] r_wgray;
   logic           r_wfull;
   logic           r_walmost_full;
   logic [ASIZE:0] r_wfree_cnt;

   logic [ASIZE:0] w_rq2;
   logic           w_accept;
   logic [ASIZE:0] w_wbin_next;
   logic [ASIZE:0] w_wgray_next;
   logic [ASIZE:0] w_full_gray;
   logic           w_wfull_next;
   logic [ASIZE:0] w_rbin;
   logic [ASIZE:0] w_used_next;
   logic [ASIZE:0] w_free_next;
   logic           w_af_next;

   sync_2ff #(
      .WIDTH(ASIZE+1)
   ) u_rptr_sync (
      .i_clk   (wclk),
      .i_rst_n (wrst_n),
      .i_d     (rptr_gray),
      .o_q     (w_rq2)
   );

   // Producer handshake: winc acts as valid and ~wfull as ready. A write is
   // taken on every wclk edge where both hold; winc while full is dropped and
   // the producer must not expect it to be retried.
   assign w_accept     = winc & ~r_wfull;
   assign w_wbin_next  = r_wbin + {{ASIZE{1'b0}}, w_accept};
   assign w_wgray_next = (ASIZE+1)'(bin2gray(32'(w_wbin_next)));

   // Full when the write pointer is exactly one lap ahead of the read pointer:
   // in Gray code that is the read pointer with its two MSBs inverted.
   assign w_full_gray  = {~w_rq2[ASIZE:ASIZE-1], w_rq2[ASIZE-2:0]};
   assign w_wfull_next = (w_wgray_next == w_full_gray);

   // Occupancy uses the synchronised (stale) read pointer, so the free count
   // can only under-report, never over-report.
   assign w_rbin      = (ASIZE+1)'(gray2bin(32'(w_rq2)));
   assign w_used_next = w_wbin_next - w_rbin;
   assign w_free_next = DEPTH_W - w_used_next;
   assign w_af_next   = (w_free_next <= AF_W);

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_wbin         <= '0;
         r_wgray        <= '0;
         r_wfull        <= 1'b0;
         r_walmost_full <= 1'b0;
         r_wfree_cnt    <= DEPTH_W;
      end else begin
         r_wbin         <= w_wbin_next;
         r_wgray        <= w_wgray_next;
         r_wfull        <= w_wfull_next;
         r_walmost_full <= w_af_next;
         r_wfree_cnt    <= w_free_next;
      end
   end

`ifdef WPTR_OVERFLOW_FLAG_EN
   logic r_woverflow;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_woverflow <= 1'b0;
      end else if (winc && r_wfull) begin
         r_woverflow <= 1'b1;
      end
   end

   assign woverflow = r_woverflow;
`endif

   assign waddr        = r_wbin[ASIZE-1:0];
   assign wclk_en      = w_accept;
   assign wptr_gray    = r_wgray;
   assign wfull        = r_wfull;
   assign walmost_full = r_walmost_full;
   assign wfree_cnt    = r_wfree_cnt;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_full
// Bench for fifo_wptr_full with ASIZE=4 (DEPTH=16), AF_LEVEL=2. Registered
// outputs are packed as {waddr, wptr_gray, wfull, walmost_full, wfree_cnt}.
// Inputs change 1 ns after a rising edge; outputs are read 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_full;

   localparam int OUT_W = 4 + 5 + 1 + 1 + 5;

   logic       wclk;
   logic       wrst_n;
   logic       winc;
   logic [4:0] rptr_gray;
   logic [3:0] waddr;
   logic       wclk_en;
   logic [4:0] wptr_gray;
   logic       wfull;
   logic       walmost_full;
   logic [4:0] wfree_cnt;
`ifdef WPTR_OVERFLOW_FLAG_EN
   logic       woverflow;
`endif

   fifo_wptr_full #(
      .DSIZE    (6),
      .ASIZE    (4),
      .AF_LEVEL (2)
   ) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .rptr_gray    (rptr_gray),
      .waddr        (waddr),
      .wclk_en      (wclk_en),
      .wptr_gray    (wptr_gray),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wfree_cnt    (wfree_cnt)
`ifdef WPTR_OVERFLOW_FLAG_EN
      ,
      .woverflow    (woverflow)
`endif
   );

   // ---------------- clock / reset ----------------
   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // ---------------- scoreboard state ----------------
   logic [OUT_W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       winc;
      logic [4:0] rptr;
      logic       en;
      logic [3:0] waddr;
      logic [4:0] wgray;
      logic       full;
      logic       af;
      logic [4:0] free;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [4:0] gray5(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [OUT_W-1:0] pack(input logic [3:0] a, input logic [4:0] g,
                                             input logic f, input logic af,
                                             input logic [4:0] fr);
      return {a, g, f, af, fr};
   endfunction

   function automatic logic [OUT_W-1:0] dut_out();
      return {waddr, wptr_gray, wfull, walmost_full, wfree_cnt};
   endfunction

   task automatic check(input string name, input logic [OUT_W-1:0] got,
                        input logic [OUT_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got {waddr,gray,full,af,free}=%h/%h/%b/%b/%0d expected %h/%h/%b/%b/%0d",
                  name, got[15:12], got[11:7], got[6], got[5], got[4:0],
                  exp[15:12], exp[11:7], exp[6], exp[5], exp[4:0]);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Drive one cycle: optionally check wclk_en before the edge, push the
   // expected registered outputs, clock, then pop and compare.
   task automatic drive(input string name, input logic i_winc, input logic [4:0] i_rptr,
                        input logic chk_en, input logic exp_en,
                        input logic [OUT_W-1:0] exp);
      logic [OUT_W-1:0] e;
      winc      = i_winc;
      rptr_gray = i_rptr;
      #1;
      if (chk_en) check_bit({name, " wclk_en"}, wclk_en, exp_en);
      exp_q.push_back(exp);
      @(posedge wclk);
      #1;
      e = exp_q.pop_front();
      check(name, dut_out(), e);
   endtask

   // ---------------- model for the wrap test ----------------
   int         m_t;
   logic [4:0] m_r1, m_r2, m_rdrv, m_used, m_free, m_tn;
   logic       m_full;

   initial begin
      // Fill table: rptr held at 0, 16 accepted writes then one while full.
      vecs[0]  = '{1'b1, 5'h00, 1'b1, 4'h1, 5'h01, 1'b0, 1'b0, 5'd15};
      vecs[1]  = '{1'b1, 5'h00, 1'b1, 4'h2, 5'h03, 1'b0, 1'b0, 5'd14};
      vecs[2]  = '{1'b1, 5'h00, 1'b1, 4'h3, 5'h02, 1'b0, 1'b0, 5'd13};
      vecs[3]  = '{1'b1, 5'h00, 1'b1, 4'h4, 5'h06, 1'b0, 1'b0, 5'd12};
      vecs[4]  = '{1'b1, 5'h00, 1'b1, 4'h5, 5'h07, 1'b0, 1'b0, 5'd11};
      vecs[5]  = '{1'b1, 5'h00, 1'b1, 4'h6, 5'h05, 1'b0, 1'b0, 5'd10};
      vecs[6]  = '{1'b1, 5'h00, 1'b1, 4'h7, 5'h04, 1'b0, 1'b0, 5'd9};
      vecs[7]  = '{1'b1, 5'h00, 1'b1, 4'h8, 5'h0C, 1'b0, 1'b0, 5'd8};
      vecs[8]  = '{1'b1, 5'h00, 1'b1, 4'h9, 5'h0D, 1'b0, 1'b0, 5'd7};
      vecs[9]  = '{1'b1, 5'h00, 1'b1, 4'hA, 5'h0F, 1'b0, 1'b0, 5'd6};
      vecs[10] = '{1'b1, 5'h00, 1'b1, 4'hB, 5'h0E, 1'b0, 1'b0, 5'd5};
      vecs[11] = '{1'b1, 5'h00, 1'b1, 4'hC, 5'h0A, 1'b0, 1'b0, 5'd4};
      vecs[12] = '{1'b1, 5'h00, 1'b1, 4'hD, 5'h0B, 1'b0, 1'b0, 5'd3};
      vecs[13] = '{1'b1, 5'h00, 1'b1, 4'hE, 5'h09, 1'b0, 1'b1, 5'd2};
      vecs[14] = '{1'b1, 5'h00, 1'b1, 4'hF, 5'h08, 1'b0, 1'b1, 5'd1};
      vecs[15] = '{1'b1, 5'h00, 1'b1, 4'h0, 5'h18, 1'b1, 1'b1, 5'd0};
      vecs[16] = '{1'b1, 5'h00, 1'b0, 4'h0, 5'h18, 1'b1, 1'b1, 5'd0};

      // ---- reset ----
      wrst_n    = 1'b0;
      winc      = 1'b0;
      rptr_gray = 5'h00;
      #12;
      check("reset values", dut_out(), pack(4'h0, 5'h00, 1'b0, 1'b0, 5'd16));
`ifdef WPTR_OVERFLOW_FLAG_EN
      check_bit("reset woverflow", woverflow, 1'b0);
`endif
      wrst_n = 1'b1;
      @(posedge wclk);
      #1;

      // ---- fill and write-while-full ----
      for (int i = 0; i < 17; i++) begin
         drive($sformatf("fill[%0d]", i), vecs[i].winc, vecs[i].rptr, 1'b1, vecs[i].en,
               pack(vecs[i].waddr, vecs[i].wgray, vecs[i].full, vecs[i].af, vecs[i].free));
      end
`ifdef WPTR_OVERFLOW_FLAG_EN
      check_bit("woverflow set", woverflow, 1'b1);
`endif
      for (int i = 0; i < 2; i++) begin
         drive("idle full", 1'b0, 5'h00, 1'b0, 1'b0, pack(4'h0, 5'h18, 1'b1, 1'b1, 5'd0));
      end

      // ---- read release: one read, visible on the 3rd edge only ----
      drive("release e1", 1'b0, 5'h01, 1'b0, 1'b0, pack(4'h0, 5'h18, 1'b1, 1'b1, 5'd0));
      drive("release e2", 1'b0, 5'h01, 1'b0, 1'b0, pack(4'h0, 5'h18, 1'b1, 1'b1, 5'd0));
      drive("release e3", 1'b0, 5'h01, 1'b0, 1'b0, pack(4'h0, 5'h18, 1'b0, 1'b1, 5'd1));
`ifdef WPTR_OVERFLOW_FLAG_EN
      check_bit("woverflow sticky", woverflow, 1'b1);
`endif

      // ---- simultaneous: write on the edge where rq2 carries a new read ----
      drive("simul e1", 1'b0, 5'h03, 1'b0, 1'b0, pack(4'h0, 5'h18, 1'b0, 1'b1, 5'd1));
      drive("simul e2", 1'b0, 5'h03, 1'b0, 1'b0, pack(4'h0, 5'h18, 1'b0, 1'b1, 5'd1));
      drive("simul wr", 1'b1, 5'h03, 1'b1, 1'b1, pack(4'h1, 5'h19, 1'b0, 1'b1, 5'd1));

      // ---- asynchronous reset mid-stream ----
      winc   = 1'b0;
      wrst_n = 1'b0;
      #1;
      check("mid reset", dut_out(), pack(4'h0, 5'h00, 1'b0, 1'b0, 5'd16));
`ifdef WPTR_OVERFLOW_FLAG_EN
      check_bit("mid reset woverflow", woverflow, 1'b0);
`endif
      rptr_gray = 5'h00;
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk);
      #1;

      // ---- wrap: read pointer trails writes by 8, 40 writes ----
      m_t    = 0;
      m_r1   = 5'd0;
      m_r2   = 5'd0;
      m_full = 1'b0;
      for (int i = 0; i < 40; i++) begin
         m_rdrv = (m_t >= 8) ? 5'((m_t - 8) % 32) : 5'd0;
         m_tn   = 5'((m_t + (m_full ? 0 : 1)) % 32);
         m_used = m_tn - m_r2;
         m_free = 5'd16 - m_used;
         m_full = (m_used == 5'd16);
         drive($sformatf("wrap[%0d]", i), 1'b1, gray5(m_rdrv), 1'b1, 1'b1,
               pack(m_tn[3:0], gray5(m_tn), m_full, (m_free <= 5'd2), m_free));
         m_t  = m_t + 1;
         m_r2 = m_r1;
         m_r1 = m_rdrv;
      end
      check_bit("wrap never full", wfull, 1'b0);

      winc = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
